cipher_arbiter: RTL and testbench
=================================

# cipher_arbiter

Two-requester scheduler that shares a single encrypt/decrypt core between two clients. It accepts one request at a time using round-robin priority, latches that request's mode, data and key, and issues a one-cycle start pulse to the core. It then tracks the core's busy indication to completion and returns the core output, or a timeout error, to the granted client through a valid/ready response channel. It sits directly above the cipher top level and is the only block that drives its start, mode, data and key inputs.

## Interface
- `BUSY_TIMEOUT`, 8: cycles allowed after the start pulse for `core_busy` to rise.
- `DONE_TIMEOUT`, 255: cycles allowed in busy before the operation is abandoned.
- `clock  in  1`: single clock, rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `r0_req_valid`, `r1_req_valid  in  1`: request pending.
- `r0_req_ready`, `r1_req_ready  out  1`: request accepted when valid & ready.
- `r0_enc_dec`, `r1_enc_dec  in  1`: 1 = encrypt, 0 = decrypt.
- `r0_data`, `r1_data  in  128`: plaintext or ciphertext.
- `r0_key`, `r1_key  in  128`: key.
- `r0_rsp_valid`, `r1_rsp_valid  out  1`: result available.
- `r0_rsp_ready`, `r1_rsp_ready  in  1`: result consumed.
- `r0_rsp_data`, `r1_rsp_data  out  128`: result; 0 on error.
- `r0_rsp_err`, `r1_rsp_err  out  1`: timeout flag; valid while rsp_valid is high.
- `core_start  out  1`: start pulse to the core.
- `core_enc_dec  out  1`: latched mode.
- `core_data`, `core_key  out  128`: latched operands.
- `core_data_out  in  128`: core result.
- `core_busy  in  1`: core operation in progress.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND.
- IDLE:
  - `grant` = round-robin choice among valid requesters. With both valid, the requester not granted last wins.
  - `rX_req_ready` = (state==IDLE) & grant==X. Requester X is accepted when `rX_req_valid` & `rX_req_ready`.
  - On acceptance: latch mode/data/key into the core_* registers, record the owner, update the last-grant pointer, and go to ISSUE.
- ISSUE: `core_start`=1 for exactly this one cycle, then go to WAIT_BUSY with the counter cleared.
- WAIT_BUSY:
  - `core_busy`=1 → WAIT_DONE, counter cleared.
  - Counter reaches `BUSY_TIMEOUT` → RESPOND with err=1.
- WAIT_DONE:
  - `core_busy`=0 → capture `core_data_out` into the result register, err=0, go to RESPOND.
  - Counter reaches `DONE_TIMEOUT` → RESPOND with err=1 and result 0.
- RESPOND:
  - Owner's `rsp_valid`=1; data and err are held stable.
  - The other requester's `rsp_valid` stays 0.
  - Go to IDLE on the owner's `rsp_ready`.
- `core_enc_dec`, `core_data` and `core_key` hold their latched values from acceptance until the next acceptance. The core's output mux depends on a stable mode, so these must not change mid-operation.
- `core_start` is low in every state except ISSUE. This guarantees at least one low cycle between pulses, so every issue produces a rising edge at the core.
- Timeout counters are 8 bits wide and saturate. A parameter value larger than 255 is a configuration error.

## Timing
- Reset (reset=0), asynchronously:
  - state=IDLE; last-grant pointer=1, so r0 wins the first tie.
  - All `rsp_valid`, `rsp_err` and `core_start` = 0.
  - Result, core_* and counter registers = 0.
- Reset mid-operation: the in-flight request is dropped with no response. After reset is released, clients must re-request.
- Latency, acceptance edge to `rsp_valid`: 1 (ISSUE) + cycles until `core_busy` rises + busy length + 1.
- With the current core (busy rises 2 cycles after the start edge), a 1-cycle busy gives `rsp_valid` 5 cycles after acceptance.
- Throughput: one operation in flight. The earliest next acceptance is the cycle after the response handshake.
- A request that deasserts valid before acceptance is simply never granted; no state is kept for it.
- `rsp_ready` asserted while `rsp_valid` is low has no effect.
- A response held with `rsp_ready`=0 stalls the arbiter indefinitely. The other requester waits.

## Structure
- Shared package `cipher_pkg`:
  - state enum (IDLE/ISSUE/WAIT_BUSY/WAIT_DONE/RESPOND);
  - `DATA_W`=128, `KEY_W`=128;
  - `TMO_W`=8.
- Sub-module `rr_arbiter2`:
  - inputs: two-bit request vector, last-grant pointer;
  - output: one-hot grant;
  - purely combinational.
- All remaining logic (FSM, operand/result registers, counters) lives in `cipher_arbiter`.

## Test plan
- Single encrypt: r0 requests enc=1 with data=0x0, key=0x0. Require: `core_start` pulses once 1 cycle after acceptance; `r0_rsp_valid` rises; `r0_rsp_data`=core model output; err=0; `r1_rsp_valid` stays 0.
- Tie: r0 and r1 valid in the same cycle, both held. Require grant order r0, r1, r0, r1 over 4 operations, with exactly one `core_start` per operation.
- Busy timeout: core model never raises busy. Require `rsp_valid` with err=1 and data=0 after `BUSY_TIMEOUT`+2 cycles; the next request then proceeds normally.
- Response backpressure: hold `r1_rsp_ready`=0 for 10 cycles while r0 is valid. Require r1's data stays stable, `r0_req_ready`=0 throughout, and r0 is granted the cycle after r1's handshake.
- Operand stability: change `r0_data`, `r0_key` and `r0_enc_dec` every cycle after acceptance. Require the core_* outputs stay at the accepted values until the response completes.
- Reset mid-operation: assert reset=0 during WAIT_DONE. Require all outputs at reset values immediately; after release, no spurious `rsp_valid` and r0 wins the first tie.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher request scheduler.
//   state_t    : scheduler FSM states
//   DATA_W     : width of plaintext / ciphertext / result words
//   KEY_W      : width of the key
//   TMO_W      : width of the busy/done timeout counter
//   sat_inc()  : saturating increment for the timeout counter
package cipher_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  localparam int DATA_W = 128;
  localparam int KEY_W  = 128;
  localparam int TMO_W  = 8;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (v == {TMO_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection (purely combinational).
//   i_req  : request vector, bit 0 = requester 0, bit 1 = requester 1
//   i_last : requester granted most recently (0 or 1)
//   o_gnt  : one-hot grant, all zero when nothing is requested
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      // Contention: the requester that was not served last goes first.
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cipher_arbiter.sv
// Shares one encrypt/decrypt core between two clients.
// One request is accepted at a time (round-robin), its mode/data/key are
// latched onto the core inputs, a single start pulse is issued, the core's
// busy line is tracked to completion (with timeouts) and the result or an
// error is handed back to the owning client over a valid/ready channel.
//   clock, reset                 : rising-edge clock, async active-low reset
//   rX_req_valid / rX_req_ready  : request handshake per client
//   rX_enc_dec, rX_data, rX_key  : request operands (1 = encrypt)
//   rX_rsp_valid / rX_rsp_ready  : response handshake per client
//   rX_rsp_data, rX_rsp_err      : result (0 on error) and timeout flag
//   core_start                   : one-cycle start pulse to the core
//   core_enc_dec/data/key        : latched operands driven to the core
//   core_data_out, core_busy     : core result and activity indication
// BUSY_TIMEOUT and DONE_TIMEOUT must fit in the 8-bit counter (<= 255).
module cipher_arbiter
  import cipher_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 8,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_req_valid,
  output logic          r0_req_ready,
  input  logic          r0_enc_dec,
  input  logic [127:0]  r0_data,
  input  logic [127:0]  r0_key,
  output logic          r0_rsp_valid,
  input  logic          r0_rsp_ready,
  output logic [127:0]  r0_rsp_data,
  output logic          r0_rsp_err,
  input  logic          r1_req_valid,
  output logic          r1_req_ready,
  input  logic          r1_enc_dec,
  input  logic [127:0]  r1_data,
  input  logic [127:0]  r1_key,
  output logic          r1_rsp_valid,
  input  logic          r1_rsp_ready,
  output logic [127:0]  r1_rsp_data,
  output logic          r1_rsp_err,
  output logic          core_start,
  output logic          core_enc_dec,
  output logic [127:0]  core_data,
  output logic [127:0]  core_key,
  input  logic [127:0]  core_data_out,
  input  logic          core_busy
);

  localparam logic [TMO_W-1:0] L_BUSY_TMO = TMO_W'(BUSY_TIMEOUT);
  localparam logic [TMO_W-1:0] L_DONE_TMO = TMO_W'(DONE_TIMEOUT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last;       // requester granted most recently
  logic                r_owner;      // requester owning the in-flight op
  logic [TMO_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_result;
  logic                r_err;
  logic                r_core_enc_dec;
  logic [DATA_W-1:0]   r_core_data;
  logic [KEY_W-1:0]    r_core_key;

  logic [1:0]          w_gnt;
  logic                w_accept;
  logic                w_owner_rsp_ready;

  rr_arbiter2 u_rr (
    .i_req  ({r1_req_valid, r0_req_valid}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_owner_rsp_ready = r_owner ? r1_rsp_ready : r0_rsp_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    r0_req_ready = 1'b0;
    r1_req_ready = 1'b0;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;
    r0_rsp_err   = 1'b0;
    r1_rsp_err   = 1'b0;
    core_start   = 1'b0;
    case (r_state)
      IDLE: begin
        r0_req_ready = w_gnt[0];
        r1_req_ready = w_gnt[1];
        // A grant is only ever given to a valid requester.
        w_accept     = |w_gnt;
        if (w_accept) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        core_start  = 1'b1;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (core_busy)                 w_state_nxt = WAIT_DONE;
        else if (r_cnt == L_BUSY_TMO)  w_state_nxt = RESPOND;
      end
      WAIT_DONE: begin
        if (!core_busy)                w_state_nxt = RESPOND;
        else if (r_cnt == L_DONE_TMO)  w_state_nxt = RESPOND;
      end
      RESPOND: begin
        r0_rsp_valid = !r_owner;
        r1_rsp_valid =  r_owner;
        r0_rsp_err   = !r_owner & r_err;
        r1_rsp_err   =  r_owner & r_err;
        if (w_owner_rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last         <= 1'b1;
      r_owner        <= 1'b0;
      r_cnt          <= '0;
      r_result       <= '0;
      r_err          <= 1'b0;
      r_core_enc_dec <= 1'b0;
      r_core_data    <= '0;
      r_core_key     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner        <= w_gnt[1];
            r_last         <= w_gnt[1];
            r_core_enc_dec <= w_gnt[1] ? r1_enc_dec : r0_enc_dec;
            r_core_data    <= w_gnt[1] ? r1_data    : r0_data;
            r_core_key     <= w_gnt[1] ? r1_key     : r0_key;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT_BUSY: begin
          if (core_busy) begin
            r_cnt <= '0;
          end else if (r_cnt == L_BUSY_TMO) begin
            r_err    <= 1'b1;
            r_result <= '0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        WAIT_DONE: begin
          if (!core_busy) begin
            r_err    <= 1'b0;
            r_result <= core_data_out;
          end else if (r_cnt == L_DONE_TMO) begin
            r_err    <= 1'b1;
            r_result <= '0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: ;
      endcase
    end
  end

  // The result register only changes on the way into RESPOND, so sharing it
  // between both clients is safe; rsp_valid tells each client when to look.
  assign r0_rsp_data  = r_result;
  assign r1_rsp_data  = r_result;
  assign core_enc_dec = r_core_enc_dec;
  assign core_data    = r_core_data;
  assign core_key     = r_core_key;

endmodule

// File: tb/tb_cipher_arbiter.sv
module tb_cipher_arbiter;

  localparam int BT = 8;
  localparam int DT = 255;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         r0_req_valid = 0, r1_req_valid = 0;
  logic         r0_req_ready, r1_req_ready;
  logic         r0_enc_dec = 0, r1_enc_dec = 0;
  logic [127:0] r0_data = '0, r1_data = '0, r0_key = '0, r1_key = '0;
  logic         r0_rsp_valid, r1_rsp_valid;
  logic         r0_rsp_ready = 0, r1_rsp_ready = 0;
  logic [127:0] r0_rsp_data, r1_rsp_data;
  logic         r0_rsp_err, r1_rsp_err;
  logic         core_start, core_enc_dec;
  logic [127:0] core_data, core_key, core_data_out;
  logic         core_busy = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  // core model controls (written by the main process only)
  int cm_d = 2, cm_L = 1;
  bit cm_nobusy = 0;
  // core model state (written by the core model process only)
  bit cm_active = 0;
  int cm_t = 0;
  int n_starts = 0;

  // scheduler reference: last granted requester
  int m_last = 1;

  always #5 clock = ~clock;

  cipher_arbiter #(.BUSY_TIMEOUT(BT), .DONE_TIMEOUT(DT)) dut (
    .clock(clock), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_enc_dec(r0_enc_dec), .r0_data(r0_data), .r0_key(r0_key),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_enc_dec(r1_enc_dec), .r1_data(r1_data), .r1_key(r1_key),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
    .core_start(core_start), .core_enc_dec(core_enc_dec),
    .core_data(core_data), .core_key(core_key),
    .core_data_out(core_data_out), .core_busy(core_busy)
  );

  // stand-in cipher transform
  function automatic logic [127:0] core_f(input logic enc, input logic [127:0] d,
                                          input logic [127:0] k);
    return enc ? ({d[63:0], d[127:64]} ^ k) : (d ^ ~k);
  endfunction

  assign core_data_out = core_f(core_enc_dec, core_data, core_key);

  // Core model: start seen in a cycle; busy is high for cm_L cycles starting
  // cm_d cycles after the start edge (or never, when cm_nobusy).
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      cm_active = 0;
      core_busy = 1'b0;
    end else begin
      if (cm_active) begin
        cm_t++;
        core_busy = !cm_nobusy && (cm_t >= cm_d + 1) && (cm_t <= cm_d + cm_L);
        if (cm_t >= (cm_nobusy ? BT + 4 : cm_d + cm_L + 1)) cm_active = 0;
      end
      if (core_start) begin
        n_starts++;
        cm_active = 1;
        cm_t      = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    r0_data = {$urandom, $urandom, $urandom, $urandom};
    r0_key  = {$urandom, $urandom, $urandom, $urandom};
    r1_data = {$urandom, $urandom, $urandom, $urandom};
    r1_key  = {$urandom, $urandom, $urandom, $urandom};
    r0_enc_dec = 1'($urandom_range(0, 1));
    r1_enc_dec = 1'($urandom_range(0, 1));
  endtask

  // One complete operation: acceptance, completion, optional response stall,
  // handshake. Called with the DUT idle and at least one request valid.
  task automatic run_op(input int d, input int L, input bit nobusy, input int stall,
                        input bit keep_valid, input bit raise_other);
    int gnt, lat, s0, exp_lat, lim;
    logic [127:0] ad, ak, exp_data, hold_data;
    logic aenc, exp_err;
    bit bad_ops, bad_rdy, bad_other, bad_hold;
    cm_d = d; cm_L = L; cm_nobusy = nobusy;
    bad_ops = 0; bad_rdy = 0; bad_other = 0; bad_hold = 0;
    @(negedge clock);
    if (r0_req_valid && r1_req_valid) gnt = (m_last == 1) ? 0 : 1;
    else                              gnt = r0_req_valid ? 0 : 1;
    check("req_ready0", 128'(r0_req_ready), 128'(gnt == 0));
    check("req_ready1", 128'(r1_req_ready), 128'(gnt == 1));
    ad   = (gnt == 0) ? r0_data : r1_data;
    ak   = (gnt == 0) ? r0_key : r1_key;
    aenc = (gnt == 0) ? r0_enc_dec : r1_enc_dec;
    s0 = n_starts;
    if (gnt == 0) r1_rsp_ready = 1'b1; else r0_rsp_ready = 1'b1;  // no-effect ready
    @(posedge clock); #1;
    m_last = gnt;
    if (!keep_valid) begin
      if (gnt == 0) r0_req_valid = 1'b0; else r1_req_valid = 1'b0;
    end
    if (raise_other) begin
      if (gnt == 0) r1_req_valid = 1'b1; else r0_req_valid = 1'b1;
    end
    @(negedge clock);
    check("start_pulse", 128'(core_start), 128'(1));
    if (nobusy) begin
      exp_lat = BT + 2; exp_err = 1'b1; exp_data = '0;
    end else if (L > DT + 1) begin
      exp_lat = d + 3 + DT; exp_err = 1'b1; exp_data = '0;
    end else begin
      exp_lat = 2 + d + L; exp_err = 1'b0; exp_data = core_f(aenc, ad, ak);
    end
    lat = 0;
    while (lat < 400) begin
      @(posedge clock); #1;
      scramble();
      lat++;
      @(negedge clock);
      if (core_data !== ad || core_key !== ak || core_enc_dec !== aenc) bad_ops = 1;
      if (r0_req_ready || r1_req_ready) bad_rdy = 1;
      if ((gnt == 0) ? r1_rsp_valid : r0_rsp_valid) bad_other = 1;
      if (((gnt == 0) ? r0_rsp_valid : r1_rsp_valid) === 1'b1) break;
    end
    check("latency", 128'(lat), 128'(exp_lat));
    check("rsp_data", (gnt == 0) ? r0_rsp_data : r1_rsp_data, exp_data);
    check("rsp_err", 128'((gnt == 0) ? r0_rsp_err : r1_rsp_err), 128'(exp_err));
    check("starts_per_op", 128'(n_starts - s0), 128'(1));
    hold_data = (gnt == 0) ? r0_rsp_data : r1_rsp_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      @(negedge clock);
      if (((gnt == 0) ? r0_rsp_valid : r1_rsp_valid) !== 1'b1) bad_hold = 1;
      if (((gnt == 0) ? r0_rsp_data : r1_rsp_data) !== hold_data) bad_hold = 1;
      if (((gnt == 0) ? r0_rsp_err : r1_rsp_err) !== exp_err) bad_hold = 1;
      if (r0_req_ready || r1_req_ready) bad_rdy = 1;
      if (core_data !== ad || core_key !== ak || core_enc_dec !== aenc) bad_ops = 1;
    end
    if (stall > 0) check("stall_hold", 128'(bad_hold), 128'(0));
    if (gnt == 0) r0_rsp_ready = 1'b1; else r1_rsp_ready = 1'b1;
    @(posedge clock); #1;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    check("operand_stable", 128'(bad_ops), 128'(0));
    check("req_ready_busy", 128'(bad_rdy), 128'(0));
    check("other_rsp_valid", 128'(bad_other), 128'(0));
    if (!nobusy && L > DT + 1) begin
      lim = 0;
      while (cm_active && lim < 400) begin
        @(posedge clock); #1;
        lim++;
      end
    end
  endtask

  initial begin
    logic [1:0] mask;
    bit spurious;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] mask;
    bit spurious;
    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_rsp_valid", 128'({r0_rsp_valid, r1_rsp_valid}), 128'(0));
    check("rst_rsp_err", 128'({r0_rsp_err, r1_rsp_err}), 128'(0));
    check("rst_core_start", 128'(core_start), 128'(0));
    check("rst_core_data", core_data, 128'(0));
    check("rst_core_key", core_key, 128'(0));
    check("rst_rsp_data", r0_rsp_data, 128'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    m_last = 1;

    // single encrypt with all-zero operands
    r0_enc_dec = 1'b1; r0_data = '0; r0_key = '0; r0_req_valid = 1'b1;
    run_op(2, 1, 0, 0, 0, 0);

    // busy never rises, then a normal op
    scramble(); r1_req_valid = 1'b1;
    run_op(0, 0, 1, 0, 0, 0);
    r1_req_valid = 1'b1;
    run_op(2, 3, 0, 0, 0, 0);

    // response backpressure on r1 while r0 waits; r0 accepted right after
    r1_req_valid = 1'b1;
    run_op(2, 2, 0, 10, 0, 1);
    run_op(1, 1, 0, 0, 0, 0);

    // busy held past the done timeout
    r0_req_valid = 1'b1;
    run_op(1, 300, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 12; i++) begin
      mask = 2'($urandom_range(1, 3));
      scramble();
      r0_req_valid = mask[0]; r1_req_valid = mask[1];
      run_op(int'($urandom_range(0, 4)), int'($urandom_range(1, 6)), 0,
             int'($urandom_range(0, 3)), 0, 0);
      r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    end

    // reset during WAIT_DONE
    scramble(); r0_req_valid = 1'b1;
    cm_d = 2; cm_L = 50; cm_nobusy = 0;
    @(negedge clock);
    check("mid_rst_accept", 128'(r0_req_ready), 128'(1));
    @(posedge clock); #1;
    r0_req_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", 128'({r0_rsp_valid, r1_rsp_valid}), 128'(0));
    check("mid_rst_err", 128'({r0_rsp_err, r1_rsp_err}), 128'(0));
    check("mid_rst_start", 128'(core_start), 128'(0));
    check("mid_rst_core", {core_data ^ core_key, 127'(0), core_enc_dec}, 256'(0) >> 128);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    m_last = 1;
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (r0_rsp_valid || r1_rsp_valid) spurious = 1;
    end
    check("post_rst_no_rsp", 128'(spurious), 128'(0));
    @(posedge clock); #1;

    // tie with both held: r0 must win first after reset, then alternate
    scramble();
    r0_req_valid = 1'b1; r1_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) run_op(2, 1 + int'($urandom_range(0, 2)), 0, 0, 1, 0);
    check("tie_last_r1", 128'(m_last), 128'(1));
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
